// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer (mtime / mtimecmp / ctrl).
//
// Drives the core's level timer interrupt `ti`. Software accesses the registers
// through a req/ack port: one access per request, acknowledged by a one-cycle
// bus_ack pulse one cycle after bus_req is first seen.
//
// Parameters
//   PRESCALE   clk cycles per mtime increment (>= 1)
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus_req    access request, held until bus_ack
//   bus_we     1 = write, 0 = read
//   bus_addr   byte address (bits [1:0] ignored)
//   bus_wdata  write data
//   bus_rdata  read data, held until the next read
//   bus_ack    one-cycle completion pulse
//   ti         timer interrupt, registered level
//
// Register map (word offsets): 0x00 mtime_lo, 0x04 mtime_hi (reads the
// snapshot taken by the last mtime_lo read), 0x08 cmp_lo, 0x0C cmp_hi,
// 0x10 ctrl {IE, EN}; 0x14..0x1C read 0 and ignore writes.
module clint_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        ti
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t        state;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [31:0]   hi_shadow;
  logic          en;
  logic          ie;
  logic [PW-1:0] pcnt;

  logic [2:0]    word;
  logic          access;
  logic          wr_mlo;
  logic          wr_mhi;
  logic          wr_clo;
  logic          wr_chi;
  logic          wr_ctrl;
  logic          tick;
  logic          inc;
  logic [31:0]   rd_mux;
  logic          unused_addr;

  assign unused_addr = ^bus_addr[1:0];
  assign word        = bus_addr[4:2];

  // The access happens on the edge that moves the FSM out of IDLE.
  assign access  = (state == IDLE) && bus_req;
  assign wr_mlo  = access && bus_we && (word == 3'd0);
  assign wr_mhi  = access && bus_we && (word == 3'd1);
  assign wr_clo  = access && bus_we && (word == 3'd2);
  assign wr_chi  = access && bus_we && (word == 3'd3);
  assign wr_ctrl = access && bus_we && (word == 3'd4);

  assign tick = en && (pcnt == PMAX);

  // A software write to either mtime half, or a ctrl write that clears EN,
  // wins over a coincident tick: that increment is dropped, never deferred.
  assign inc = tick && !wr_mlo && !wr_mhi && !(wr_ctrl && !bus_wdata[0]);

  always_comb begin
    rd_mux = 32'd0;
    case (word)
      3'd0:    rd_mux = mtime[31:0];
      3'd1:    rd_mux = hi_shadow;
      3'd2:    rd_mux = mtimecmp[31:0];
      3'd3:    rd_mux = mtimecmp[63:32];
      3'd4:    rd_mux = {30'd0, ie, en};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_shadow <= 32'd0;
      en        <= 1'b0;
      ie        <= 1'b0;
      pcnt      <= '0;
      bus_rdata <= 32'd0;
      bus_ack   <= 1'b0;
      ti        <= 1'b0;
    end else begin
      if (en) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
      end

      if (wr_mlo) begin
        mtime[31:0] <= bus_wdata;
      end else if (wr_mhi) begin
        mtime[63:32] <= bus_wdata;
      end else if (inc) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_clo) mtimecmp[31:0]  <= bus_wdata;
      if (wr_chi) mtimecmp[63:32] <= bus_wdata;
      if (wr_ctrl) begin
        en <= bus_wdata[0];
        ie <= bus_wdata[1];
      end

      // Reading mtime_lo snapshots the upper half so a following mtime_hi
      // read pairs with it even if the low word has since rolled over.
      if (access && !bus_we) begin
        bus_rdata <= rd_mux;
        if (word == 3'd0) hi_shadow <= mtime[63:32];
      end

      ti <= ie && (mtime >= mtimecmp);

      case (state)
        IDLE: begin
          if (bus_req) begin
            state   <= ACK;
            bus_ack <= 1'b1;
          end
        end
        ACK: begin
          state   <= WAIT;
          bus_ack <= 1'b0;
        end
        WAIT: begin
          if (!bus_req) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer. Two instances share the clock and reset:
// u4 uses PRESCALE=4, u1 uses PRESCALE=1; `sel` steers the bus to one of them.
// Read expectations are computed from a behavioural model when the request is
// driven, queued, and compared when bus_ack arrives.
module tb_clint_timer;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  int          sel;

  logic        req0, req1;
  logic [31:0] rdata0, rdata1, rdata;
  logic        ack0, ack1, ack;
  logic        ti0, ti1;

  assign req0  = req && (sel == 0);
  assign req1  = req && (sel == 1);
  assign rdata = (sel == 1) ? rdata1 : rdata0;
  assign ack   = (sel == 1) ? ack1 : ack0;

  clint_timer #(.PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .bus_req(req0), .bus_we(we), .bus_addr(addr),
    .bus_wdata(wdata), .bus_rdata(rdata0), .bus_ack(ack0), .ti(ti0)
  );

  clint_timer #(.PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .bus_req(req1), .bus_we(we), .bus_addr(addr),
    .bus_wdata(wdata), .bus_rdata(rdata1), .bus_ack(ack1), .ti(ti1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == n between rising edge n and rising edge n+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic ti_h0 [0:8191];
  logic ti_h1 [0:8191];
  always @(negedge clk) begin
    if (cyc < 8192) begin
      ti_h0[cyc] <= ti0;
      ti_h1[cyc] <= ti1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  // Behavioural model, one slot per instance
  logic [63:0] m_base   [2];
  int          m_edge   [2];
  bit          m_en     [2];
  logic [63:0] m_cmp    [2];
  logic [1:0]  m_ctrl   [2];
  logic [31:0] m_shadow [2];

  function automatic int ps(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  // mtime value held after rising edge n
  function automatic logic [63:0] mt(input int s, input int n);
    int q;
    if (!m_en[s]) return m_base[s];
    q = (n - m_edge[s]) / ps(s);
    return m_base[s] + 64'(q);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_base[s]   = 64'd0;
      m_edge[s]   = 0;
      m_en[s]     = 1'b0;
      m_cmp[s]    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ctrl[s]   = 2'd0;
      m_shadow[s] = 32'd0;
    end
  endtask

  task automatic model_write(input int s, input logic [4:0] a, input logic [31:0] d, input int e);
    logic [63:0] cur;
    cur = mt(s, e - 1);
    case (a[4:2])
      3'd0: begin m_base[s] = {cur[63:32], d}; m_edge[s] = e; end
      3'd1: begin m_base[s] = {d, cur[31:0]}; m_edge[s] = e; end
      3'd2: m_cmp[s][31:0]  = d;
      3'd3: m_cmp[s][63:32] = d;
      3'd4: begin
        if (d[0] != m_en[s]) begin
          m_base[s] = cur;
          m_edge[s] = e;
        end
        m_en[s]   = d[0];
        m_ctrl[s] = d[1:0];
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input int s, input logic [4:0] a, input int e, output logic [31:0] x);
    logic [63:0] cur;
    cur = mt(s, e - 1);
    case (a[4:2])
      3'd0: begin x = cur[31:0]; m_shadow[s] = cur[63:32]; end
      3'd1: x = m_shadow[s];
      3'd2: x = m_cmp[s][31:0];
      3'd3: x = m_cmp[s][63:32];
      3'd4: x = {30'd0, m_ctrl[s]};
      default: x = 32'd0;
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; the access lands on the next rising edge (e).
  // Returns at a falling edge with the FSM back in IDLE.
  task automatic xfer(input int s, input bit w, input logic [4:0] a, input logic [31:0] d,
                      input string tag, output int e);
    logic [31:0] x;
    int k;
    e = cyc + 1;
    if (w) begin
      model_write(s, a, d, e);
    end else begin
      model_read(s, a, e, x);
      exp_q.push_back(x);
      tag_q.push_back(tag);
    end
    sel = s; req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    check({tag, "_ack_latency"}, ack, 1'b1);
    k = 0;
    while (!ack && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ack) check({tag, "_ack_timeout"}, 1'b0, 1'b1);
    if (!w) check(tag_q.pop_front(), rdata, exp_q.pop_front());
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, ack, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int s, input logic [4:0] a, input logic [31:0] d, output int e);
    xfer(s, 1'b1, a, d, "wr", e);
  endtask

  task automatic rd(input int s, input logic [4:0] a, input string tag);
    int e;
    xfer(s, 1'b0, a, 32'd0, tag, e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int e, e0, ew, a0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_ack0", ack0, 1'b0);
    check("rst_ti0", ti0, 1'b0);
    a0 = cyc;
    rd(0, 5'h00, "rst_mtime_lo");
    rd(0, 5'h04, "rst_mtime_hi");
    rd(0, 5'h08, "rst_cmp_lo");
    rd(0, 5'h0C, "rst_cmp_hi");
    rd(0, 5'h10, "rst_ctrl");
    for (int n = a0; n < cyc; n += 4) check("rst_ti_quiet", ti_h0[n], 1'b0);

    // Handshake: request held for 6 cycles produces one ack and one write
    e = cyc + 1;
    model_write(1, 5'h10, 32'd1, e);
    sel = 1; req = 1'b1; we = 1'b1; addr = 5'h10; wdata = 32'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check((i == 0) ? "held_ack_first" : "held_ack_repeat", ack, (i == 0) ? 1'b1 : 1'b0);
    end
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rd(1, 5'h10, "held_ctrl");
    rd(1, 5'h00, "held_mtime_lo");
    rd(1, 5'h18, "unmapped_rd");
    wr(1, 5'h14, 32'hFFFF_FFFF, e);
    rd(1, 5'h10, "unmapped_wr_ctrl");

    // Wrap through 2^64 and lo/hi snapshot coherence
    wr(1, 5'h10, 32'd0, e);
    wr(1, 5'h04, 32'hFFFF_FFFF, e);
    wr(1, 5'h00, 32'hFFFF_FFFE, e);
    wr(1, 5'h10, 32'd1, e);
    rd(1, 5'h00, "wrap_lo");
    rd(1, 5'h04, "wrap_hi");
    wr(1, 5'h10, 32'd0, e);
    wr(1, 5'h04, 32'd1, e);
    wr(1, 5'h00, 32'hFFFF_FFFD, e);
    wr(1, 5'h10, 32'd1, e);
    rd(1, 5'h00, "snap_lo");
    rd(1, 5'h04, "snap_hi");

    // Write to mtime_lo on a tick edge: written value, no increment
    wr(1, 5'h00, 32'd5, e);
    rd(1, 5'h00, "collide_lo");
    rd(1, 5'h04, "collide_hi");

    // IE gating
    wr(1, 5'h0C, 32'd0, e);
    wr(1, 5'h08, 32'd0, ew);
    wait_cyc(ew + 3);
    check("ie0_ti_a", ti_h1[ew + 1], 1'b0);
    check("ie0_ti_b", ti_h1[ew + 2], 1'b0);
    wr(1, 5'h10, 32'd3, ew);
    check("ie1_ti_edge", ti_h1[ew], 1'b0);
    check("ie1_ti_next", ti_h1[ew + 1], 1'b1);

    // Prescaled count and compare on the PRESCALE=4 instance
    wr(0, 5'h0C, 32'd0, e);
    wr(0, 5'h08, 32'd10, e);
    wr(0, 5'h10, 32'd3, e0);
    rd(0, 5'h00, "psc_lo_a");
    rd(0, 5'h00, "psc_lo_b");
    rd(0, 5'h00, "psc_lo_c");
    wait_cyc(e0 + 42);
    check("psc_ti_before", ti_h0[e0 + 40], 1'b0);
    check("psc_ti_rise", ti_h0[e0 + 41], 1'b1);
    wr(0, 5'h08, 32'd100, ew);
    check("psc_ti_hold", ti_h0[ew], 1'b1);
    check("psc_ti_drop", ti_h0[ew + 1], 1'b0);

    // Reset asserted while bus_ack is high
    sel = 0; req = 1'b1; we = 1'b1; addr = 5'h08; wdata = 32'h55;
    @(posedge clk); #1;
    check("rst_mid_ack_pre", ack, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack_drop", ack, 1'b0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_mid_rdata", rdata0, 32'd0);
    check("rst_mid_ti", ti0, 1'b0);
    rd(0, 5'h08, "rst_mid_cmp_lo");
    rd(0, 5'h10, "rst_mid_ctrl");
    rd(0, 5'h00, "rst_mid_mtime_lo");
    rd(1, 5'h04, "rst_mid_u1_hi");

    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
